// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a tagged BTB paired with a table of 2-bit saturating counters.
// The IF stage looks up pred_pc combinationally and gets a taken/target prediction with no
// latency. The MEM stage trains the tables through the upd_* port, and the block counts
// resolved branches and mispredictions.
//
// Optional feature: define BP_GSHARE_EN to add a GHR_W-bit global history register. The
// history is XORed into the counter-table index, while the BTB stays indexed by PC bits only.
module branch_predictor #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned GHR_W   = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    // IF-stage lookup
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    // MEM-stage training
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    // Performance counters
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    localparam logic [1:0] CtrWeakNotTaken = 2'b01;
    localparam logic [1:0] CtrWeakTaken    = 2'b10;
    localparam logic [1:0] CtrStrongTaken  = 2'b11;
    localparam logic [1:0] CtrStrongNot    = 2'b00;

    // Table state
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    // Performance counters
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // History folded into the counter index; all zeros when gshare is not built in.
    logic [GHR_W-1:0] hist;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // Global history register: shifts in each resolved outcome, newest in bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Next history value; truncating the concatenation drops the oldest outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = GHR_W'({ghr_q, upd_taken});
        end
    end

    assign hist = ghr_q;
`else
    assign hist = '0;
`endif

    // Lookup-side index/tag decode
    logic [IDX_W-1:0] p_idx;
    logic [IDX_W-1:0] p_cidx;
    logic [TAG_W-1:0] p_tag;
    logic             p_hit;

    // Update-side index/tag decode
    logic [IDX_W-1:0] u_idx;
    logic [IDX_W-1:0] u_cidx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    // Only the index/tag slice of upd_pc is meaningful to the tables.
    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc;

    assign p_idx  = pred_pc[IDX_W+1:2];
    assign p_tag  = pred_pc[TAG_HI:TAG_LO];
    assign p_cidx = p_idx ^ IDX_W'(hist);
    assign u_idx  = upd_pc[IDX_W+1:2];
    assign u_tag  = upd_pc[TAG_HI:TAG_LO];
    // Training uses the history as it stood before this update shifts it.
    assign u_cidx = u_idx ^ IDX_W'(hist);

    // Hit detection for both ports, from registered state only (no update bypass).
    always_comb begin
        p_hit = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    end

    // Prediction outputs: BTB target on a taken prediction, otherwise sequential fetch.
    always_comb begin
        pred_taken  = p_hit && ctr_q[p_cidx][1];
        pred_target = pred_pc + XLEN'(4);
        if (pred_taken) begin
            pred_target = target_q[p_idx];
        end
    end

    // Table training: saturating counter update on a hit, allocate on a taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    target_d[u_idx] = upd_target;
                    if (ctr_q[u_cidx] != CtrStrongTaken) begin
                        ctr_d[u_cidx] = ctr_q[u_cidx] + 2'd1;
                    end
                end else if (ctr_q[u_cidx] != CtrStrongNot) begin
                    ctr_d[u_cidx] = ctr_q[u_cidx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Overwrites whatever aliased entry lived here before.
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
                ctr_d[u_cidx]   = CtrWeakTaken;
            end
        end
    end

    // Table state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CtrWeakNotTaken;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
        end
    end

    // Performance counter next state; both stick at all-ones instead of wrapping.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_valid) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if ((upd_taken != upd_pred_taken) && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=16, TAG_W=8, CNT_W=4).
module tb_branch_predictor;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int tests;
    int fails;

    branch_predictor #(
        .XLEN    (XLEN),
        .ENTRIES (16),
        .TAG_W   (8),
        .GHR_W   (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        uv;
        logic [63:0] upc;
        logic        ut;
        logic [63:0] utgt;
        logic        upt;
        logic [63:0] lpc;
        logic        exp_taken;
        logic [63:0] exp_tgt;
        int          exp_br;
        int          exp_mp;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic uv, input logic [63:0] upc, input logic ut,
                                input logic [63:0] utgt, input logic upt,
                                input logic [63:0] lpc, input logic et,
                                input logic [63:0] etgt, input int br, input int mp);
        vec_t v;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.lpc = lpc; v.exp_taken = et; v.exp_tgt = etgt; v.exp_br = br; v.exp_mp = mp;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic et, input logic [63:0] etgt,
                             input int br, input int mp);
        check({tag, " taken"},   64'(pred_taken),  64'(et));
        check({tag, " target"},  pred_target,      etgt);
        check({tag, " br_cnt"},  64'(branch_cnt),  64'(br));
        check({tag, " mp_cnt"},  64'(mispred_cnt), 64'(mp));
    endtask

    // Drive one cycle: inputs just after posedge, compare at negedge, update at next posedge.
    task automatic apply(input vec_t v, input int n);
        upd_valid      = v.uv;
        upd_pc         = v.upc;
        upd_taken      = v.ut;
        upd_target     = v.utgt;
        upd_pred_taken = v.upt;
        pred_pc        = v.lpc;
        @(negedge clk);
        check_all($sformatf("v%0d", n), v.exp_taken, v.exp_tgt, v.exp_br, v.exp_mp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [63:0] pc, input logic t, input logic [63:0] tgt,
                             input logic pt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_pred_taken = pt;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        upd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0;
        pred_pc = 64'h100;

        // Outputs while reset is held.
        #12;
        check_all("in_reset", 1'b0, 64'h104, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        //             uv  upc     ut  utgt    upt lpc     et  etgt    br  mp
        vecs[0]  = mk(0, 64'h0,   0, 64'h0,   0, 64'h100, 0, 64'h104, 0, 0);
        vecs[1]  = mk(1, 64'h100, 1, 64'h200, 0, 64'h100, 0, 64'h104, 0, 0);
        vecs[2]  = mk(0, 64'h0,   0, 64'h0,   0, 64'h100, 1, 64'h200, 1, 1);
        vecs[3]  = mk(1, 64'h100, 0, 64'h0,   1, 64'h100, 1, 64'h200, 1, 1);
        vecs[4]  = mk(1, 64'h100, 0, 64'h0,   0, 64'h100, 0, 64'h104, 2, 2);
        vecs[5]  = mk(1, 64'h100, 0, 64'h0,   0, 64'h100, 0, 64'h104, 3, 2);
        vecs[6]  = mk(1, 64'h100, 1, 64'h240, 0, 64'h100, 0, 64'h104, 4, 2);
        vecs[7]  = mk(1, 64'h100, 1, 64'h200, 0, 64'h100, 0, 64'h104, 5, 3);
        vecs[8]  = mk(0, 64'h0,   0, 64'h0,   0, 64'h100, 1, 64'h200, 6, 4);
        vecs[9]  = mk(0, 64'h0,   0, 64'h0,   0, 64'h140, 0, 64'h144, 6, 4);
        vecs[10] = mk(1, 64'h140, 0, 64'h0,   0, 64'h100, 1, 64'h200, 6, 4);
        vecs[11] = mk(0, 64'h0,   0, 64'h0,   0, 64'h140, 0, 64'h144, 7, 4);
        vecs[12] = mk(1, 64'h140, 1, 64'h300, 0, 64'h140, 0, 64'h144, 7, 4);
        vecs[13] = mk(0, 64'h0,   0, 64'h0,   0, 64'h140, 1, 64'h300, 8, 5);
        vecs[14] = mk(0, 64'h0,   0, 64'h0,   0, 64'h100, 0, 64'h104, 8, 5);
        vecs[15] = mk(1, 64'h104, 1, 64'h80,  1, 64'h104, 0, 64'h108, 8, 5);
        vecs[16] = mk(0, 64'h0,   0, 64'h0,   0, 64'h104, 1, 64'h80,  9, 5);
        // upd_valid low with live-looking update fields: nothing may change.
        vecs[17] = mk(0, 64'h104, 0, 64'h999, 1, 64'h140, 1, 64'h300, 9, 5);
        vecs[18] = mk(0, 64'h0,   0, 64'h0,   0, 64'h104, 1, 64'h80,  9, 5);
        vecs[19] = mk(0, 64'h0,   0, 64'h0,   0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 9, 5);

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        // Counter saturation: 20 mispredicted not-taken misses (no table change).
        for (int i = 0; i < 20; i++) begin
            int eb;
            int em;
            do_update(64'h180, 1'b0, 64'h0, 1'b1);
            eb = (9 + i + 1 > 15) ? 15 : 9 + i + 1;
            em = (5 + i + 1 > 15) ? 15 : 5 + i + 1;
            check($sformatf("sat%0d br_cnt", i), 64'(branch_cnt),  64'(eb));
            check($sformatf("sat%0d mp_cnt", i), 64'(mispred_cnt), 64'(em));
        end
        pred_pc = 64'h140;
        #1;
        check("sat table_untouched", 64'(pred_taken), 64'(1));

        // Reset asserted mid-cycle with an update pending: outputs drop immediately.
        upd_valid = 1'b1; upd_pc = 64'h140; upd_taken = 1'b1; upd_target = 64'h500;
        upd_pred_taken = 1'b0; pred_pc = 64'h140;
        #2;
        rst = 1'b0;
        #1;
        check_all("rst_now", 1'b0, 64'h144, 0, 0);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all("post_rst 140", 1'b0, 64'h144, 0, 0);
        pred_pc = 64'h104;
        #1;
        check("post_rst 104 taken", 64'(pred_taken), 64'(0));

`ifdef BP_GSHARE_EN
        // Alternating T/N at one PC trains two history-selected counters.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_update(64'h100, (i % 2 == 0), 64'h200, 1'b0);
        end
        pred_pc = 64'h100;
        @(negedge clk);
        check("gshare T taken",  64'(pred_taken), 64'(1));
        check("gshare T target", pred_target,     64'h200);
        @(posedge clk);
        #1;
        do_update(64'h100, 1'b1, 64'h200, 1'b0);
        @(negedge clk);
        check("gshare N taken",  64'(pred_taken), 64'(0));
        check("gshare N target", pred_target,     64'h104);
`else
        do_reset();
        pred_pc = 64'h100;
        @(negedge clk);
        check_all("final_rst", 1'b0, 64'h104, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
